gts_inducer_ctrl: RTL

GTS_INDUCER_CTRL -- requirements
Module: gts_inducer_ctrl

---
 rtl/gts_inducer_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gts_inducer_ctrl.sv
// gts_inducer_ctrl: drives IPTG/aTc to flip a genetic toggle switch, using synchronized GFP as feedback.
// Optional INDUCE/SETTLE abort timer is built when GTS_INDUCER_TIMEOUT_EN is defined.
module gts_inducer_ctrl #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int RELAX_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 20,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_dir,
    output logic cmd_ready,
    input  logic GFP,
    output logic IPTG,
    output logic aTc,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_MAX ||
        RELAX_CYCLES < 1 || RELAX_CYCLES > CNT_MAX ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > CNT_MAX) begin : g_param_check
        $error("gts_inducer_ctrl: cycle parameters must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RELAX_LIM  = CNT_W'(RELAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INDUCE   = 3'd1,
        S_SETTLE   = 3'd2,
        S_WITHDRAW = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state;
    logic             tgt;
    logic [1:0]       gfp_sync;
    logic             gfp_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] settle_next;
    logic             on_tgt;
    logic             timed_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign gfp_s       = gfp_sync[1];
    assign on_tgt      = (gfp_s == tgt);
    // INDUCE counts its own matching cycle as the first settle cycle.
    assign settle_next = (state == S_SETTLE) ? sat_inc(cnt) : CNT_W'(1);

`ifdef GTS_INDUCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tcnt;

    assign timed_out = (tcnt >= TIMEOUT_LIM);

    // Abort timer: counts INDUCE/SETTLE cycles since acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == S_IDLE) begin
            tcnt <= CNT_W'(1);
        end else if (state == S_INDUCE || state == S_SETTLE) begin
            tcnt <= sat_inc(tcnt);
        end else begin
            tcnt <= tcnt;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous reporter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gfp_sync <= 2'b00;
        end else begin
            gfp_sync <= {gfp_sync[0], GFP};
        end
    end

    // Command sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tgt       <= 1'b0;
            cnt       <= '0;
            IPTG      <= 1'b0;
            aTc       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state     <= S_INDUCE;
                        tgt       <= cmd_dir;
                        cnt       <= '0;
                        IPTG      <= cmd_dir;
                        aTc       <= ~cmd_dir;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_INDUCE, S_SETTLE: begin
                    // Completing the settle window wins over a simultaneous timeout.
                    if (on_tgt && settle_next >= SETTLE_LIM) begin
                        state <= S_WITHDRAW;
                        cnt   <= '0;
                        IPTG  <= 1'b0;
                        aTc   <= 1'b0;
                    end else if (timed_out) begin
                        state <= S_DONE;
                        IPTG  <= 1'b0;
                        aTc   <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (on_tgt) begin
                        state <= S_SETTLE;
                        cnt   <= settle_next;
                    end else begin
                        state <= S_INDUCE;
                        cnt   <= '0;
                    end
                end
                S_WITHDRAW: begin
                    if (!on_tgt) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (sat_inc(cnt) >= RELAX_LIM) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    IPTG      <= 1'b0;
                    aTc       <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
